// File: rtl/io_bank_pkg.sv
// Shared constants for the I/O window responder: register offsets, STATUS
// bit positions and the UART transmitter state encoding.
package io_bank_pkg;

    localparam logic [7:0] IO_GPIO_OUT  = 8'h00;
    localparam logic [7:0] IO_GPIO_IN   = 8'h04;
    localparam logic [7:0] IO_TIMER     = 8'h08;
    localparam logic [7:0] IO_TIMER_CMP = 8'h0C;
    localparam logic [7:0] IO_UART_TX   = 8'h10;
    localparam logic [7:0] IO_STATUS    = 8'h14;

    localparam int ST_TX_FULL       = 0;
    localparam int ST_TX_EMPTY      = 1;
    localparam int ST_TIMER_PENDING = 2;
    localparam int ST_TX_OVERFLOW   = 3;
    localparam int ST_TX_BUSY       = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/io_uart_tx.sv
// UART transmitter: small byte FIFO feeding an 8N1 serializer with a
// per-bit cycle counter. Line idles high.
module io_uart_tx
    import io_bank_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 104,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       clr_overflow,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       uart_tx
);

    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(TX_FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0]    mem_q [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          do_push, pop;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;

    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push.
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign overflow = ovf_q;
    assign busy     = (state_q != TX_IDLE);
    assign do_push  = push && !full;

    always_comb begin
        count_d = count_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (push && full) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        uart_tx = 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                uart_tx = shreg_q[0];
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/io_bank.sv
// I/O window responder: zero-latency read mux, GPIO, input synchronizer,
// compare timer and the UART transmitter.
module io_bank
    import io_bank_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 104,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic [7:0]  gpio_out,
    input  logic [7:0]  gpio_in,
    output logic        uart_tx,
    output logic        timer_irq
);

    logic [7:0]  addr_w;
    logic        wr, wr_gpio, wr_timer, wr_cmp, wr_uart, wr_status;
    logic [7:0]  gpio_q, gpio_sync1_q, gpio_sync2_q;
    logic [31:0] timer_q, timer_d, cmp_q;
    logic        pending_q, pending_d;
    logic        tx_full, tx_empty, tx_overflow, tx_busy;
    logic [31:0] status_w;
    logic        unused_addr_lsbs;

    // Byte lanes are not supported; every access is a full word.
    assign addr_w           = {io_addr[7:2], 2'b00};
    assign unused_addr_lsbs = ^io_addr[1:0];

    assign wr        = io_en && io_we;
    assign wr_gpio   = wr && (addr_w == IO_GPIO_OUT);
    assign wr_timer  = wr && (addr_w == IO_TIMER);
    assign wr_cmp    = wr && (addr_w == IO_TIMER_CMP);
    assign wr_uart   = wr && (addr_w == IO_UART_TX);
    assign wr_status = wr && (addr_w == IO_STATUS);

    assign gpio_out  = gpio_q;
    assign timer_irq = pending_q;

    always_comb begin
        timer_d = wr_timer ? io_data_write : timer_q + 32'd1;
        pending_d = pending_q;
        // A compare match beats a simultaneous clear so no event is lost.
        if (timer_q == cmp_q) begin
            pending_d = 1'b1;
        end else if (wr_status && io_data_write[ST_TIMER_PENDING]) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q       <= '0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
            timer_q      <= '0;
            cmp_q        <= 32'hFFFF_FFFF;
            pending_q    <= 1'b0;
        end else begin
            if (wr_gpio) begin
                gpio_q <= io_data_write[7:0];
            end
            if (wr_cmp) begin
                cmp_q <= io_data_write;
            end
            gpio_sync1_q <= gpio_in;
            gpio_sync2_q <= gpio_sync1_q;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
        end
    end

    always_comb begin
        status_w                   = '0;
        status_w[ST_TX_FULL]       = tx_full;
        status_w[ST_TX_EMPTY]      = tx_empty;
        status_w[ST_TIMER_PENDING] = pending_q;
        status_w[ST_TX_OVERFLOW]   = tx_overflow;
        status_w[ST_TX_BUSY]       = tx_busy;
    end

    always_comb begin
        io_data_read = '0;
        if (io_en) begin
            case (addr_w)
                IO_GPIO_OUT:  io_data_read = {24'b0, gpio_q};
                IO_GPIO_IN:   io_data_read = {24'b0, gpio_sync2_q};
                IO_TIMER:     io_data_read = timer_q;
                IO_TIMER_CMP: io_data_read = cmp_q;
                IO_STATUS:    io_data_read = status_w;
                default:      io_data_read = '0;
            endcase
        end
    end

    io_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .TX_FIFO_DEPTH(TX_FIFO_DEPTH)
    ) u_uart_tx (
        .clk         (clk),
        .reset       (reset),
        .push        (wr_uart),
        .push_data   (io_data_write[7:0]),
        .clr_overflow(wr_status && io_data_write[ST_TX_OVERFLOW]),
        .full        (tx_full),
        .empty       (tx_empty),
        .overflow    (tx_overflow),
        .busy        (tx_busy),
        .uart_tx     (uart_tx)
    );

endmodule

// File: tb/tb_io_bank.sv
// Directed bench for io_bank: register table, timer compare, UART framing,
// FIFO overflow and reset in the middle of a frame.
module tb_io_bank;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in;
    logic        uart_tx;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    io_bank #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_addr      (io_addr),
        .io_en        (io_en),
        .io_we        (io_we),
        .io_data_write(io_data_write),
        .io_data_read (io_data_read),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in),
        .uart_tx      (uart_tx),
        .timer_irq    (timer_irq)
    );

    typedef struct {
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we, input logic [7:0] addr, input logic [31:0] data);
        io_en         = en;
        io_we         = we;
        io_addr       = addr;
        io_data_write = data;
    endtask

    // Line level r cycles into a frame carrying byte b (start, 8 data LSB first, stop).
    function automatic logic frame_bit(input logic [7:0] b, input int r);
        int s;
        s = r / CPB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s-1];
    endfunction

    logic [7:0] obytes [6];
    logic       exp_tx;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h14, 32'h0,         32'h0000_0002, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h0C, 32'h0,         32'hFFFF_FFFF, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_0000, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 8'h00, 32'h0000_00A5, 32'h0000_0000, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_00A5, 8'hA5};
        vecs[5]  = '{1'b1, 1'b0, 8'h40, 32'h0,         32'h0000_0000, 8'hA5};
        vecs[6]  = '{1'b1, 1'b0, 8'h04, 32'h0,         32'h0000_003C, 8'hA5};
        vecs[7]  = '{1'b1, 1'b0, 8'h10, 32'h0,         32'h0000_0000, 8'hA5};
        vecs[8]  = '{1'b0, 1'b0, 8'h0C, 32'h0,         32'h0000_0000, 8'hA5};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 32'h0,         32'h0000_0000, 8'hA5};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_00A5, 8'hA5};
        vecs[11] = '{1'b1, 1'b1, 8'h00, 32'hFFFF_FF5A, 32'h0000_00A5, 8'hA5};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_005A, 8'h5A};
        vecs[13] = '{1'b1, 1'b1, 8'h80, 32'hDEAD_BEEF, 32'h0000_0000, 8'h5A};
        vecs[14] = '{1'b1, 1'b0, 8'h80, 32'h0,         32'h0000_0000, 8'h5A};
        vecs[15] = '{1'b1, 1'b1, 8'h18, 32'h1234_5678, 32'h0000_0000, 8'h5A};
        vecs[16] = '{1'b1, 1'b0, 8'h0E, 32'h0,         32'hFFFF_FFFF, 8'h5A};
        vecs[17] = '{1'b1, 1'b0, 8'h18, 32'h0,         32'h0000_0000, 8'h5A};
        obytes[0] = 8'h11; obytes[1] = 8'h22; obytes[2] = 8'h33;
        obytes[3] = 8'h44; obytes[4] = 8'h55; obytes[5] = 8'h66;

        reset   = 1'b1;
        gpio_in = 8'h3C;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) cyc();
        chk("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        chk("reset_timer_irq", {31'b0, timer_irq}, 32'h0);
        chk("reset_gpio_out", {24'b0, gpio_out}, 32'h0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d_rd", i), io_data_read, vecs[i].exp_rd);
            chk($sformatf("vec%0d_gpio", i), {24'b0, gpio_out}, {24'b0, vecs[i].exp_gpio});
            $display("vec %0d en=%0b we=%0b addr=0x%02h wdata=0x%08h rd=0x%08h gpio=0x%02h",
                     i, io_en, io_we, io_addr, io_data_write, io_data_read, gpio_out);
            cyc();
        end

        // Input synchronizer: new value visible after two edges.
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        gpio_in = 8'hC3;
        cyc();
        drive(1'b1, 1'b0, 8'h04, 32'h0);
        #1;
        chk("gpio_in_1edge", io_data_read, 32'h0000_003C);
        cyc();
        #1;
        chk("gpio_in_2edge", io_data_read, 32'h0000_00C3);
        $display("seq gpio_in sync rd=0x%08h", io_data_read);

        // Timer compare: irq rises 6 cycles after the TIMER write edge.
        drive(1'b1, 1'b1, 8'h08, 32'd10);
        cyc();
        drive(1'b1, 1'b1, 8'h0C, 32'd15);
        cyc();
        drive(1'b1, 1'b0, 8'h08, 32'h0);
        #1;
        chk("timer_read_k1", io_data_read, 32'd11);
        chk("timer_irq_k1", {31'b0, timer_irq}, 32'h0);
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        for (int k = 2; k <= 7; k++) begin
            cyc();
            chk($sformatf("timer_irq_k%0d", k), {31'b0, timer_irq}, (k >= 6) ? 32'h1 : 32'h0);
        end
        $display("seq timer compare irq=%0b", timer_irq);
        drive(1'b1, 1'b1, 8'h14, 32'h4);
        cyc();
        drive(1'b1, 1'b0, 8'h14, 32'h0);
        #1;
        chk("timer_w1c_irq", {31'b0, timer_irq}, 32'h0);
        chk("timer_w1c_status", io_data_read, 32'h0000_0002);
        drive(1'b1, 1'b1, 8'h08, 32'd15);
        cyc();
        drive(1'b1, 1'b1, 8'h14, 32'h4);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        chk("w1c_vs_match_irq", {31'b0, timer_irq}, 32'h1);
        drive(1'b1, 1'b1, 8'h14, 32'h4);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        chk("w1c_after_match_irq", {31'b0, timer_irq}, 32'h0);
        $display("seq timer w1c irq=%0b", timer_irq);

        // Single UART frame of 0x55.
        drive(1'b1, 1'b1, 8'h10, 32'h0000_0055);
        cyc();
        drive(1'b1, 1'b0, 8'h14, 32'h0);
        #1;
        chk("uart_idle_obs_status", io_data_read, 32'h0000_0000);
        chk("uart_idle_obs_tx", {31'b0, uart_tx}, 32'h1);
        cyc();
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i == 10) drive(1'b1, 1'b0, 8'h14, 32'h0);
            else         drive(1'b0, 1'b0, 8'h00, 32'h0);
            #1;
            chk($sformatf("frame55_c%0d", i), {31'b0, uart_tx}, {31'b0, frame_bit(8'h55, i)});
            if (i == 10) chk("frame55_busy_status", io_data_read, 32'h0000_0012);
            cyc();
        end
        drive(1'b1, 1'b0, 8'h14, 32'h0);
        #1;
        chk("frame55_end_tx", {31'b0, uart_tx}, 32'h1);
        chk("frame55_end_status", io_data_read, 32'h0000_0002);
        $display("seq uart frame 0x55 done");
        cyc();

        // Six back-to-back pushes: one shifts, four queue, the sixth is dropped.
        for (int t = 0; t < 240; t++) begin
            if (t < 6)       drive(1'b1, 1'b1, 8'h10, {24'b0, obytes[t]});
            else if (t == 6) drive(1'b1, 1'b0, 8'h14, 32'h0);
            else if (t == 7) drive(1'b1, 1'b1, 8'h14, 32'h8);
            else if (t == 8) drive(1'b1, 1'b0, 8'h14, 32'h0);
            else             drive(1'b0, 1'b0, 8'h00, 32'h0);
            #1;
            exp_tx = 1'b1;
            if (t >= 2 && ((t - 2) / 41) < 5 && ((t - 2) % 41) < 40)
                exp_tx = frame_bit(obytes[(t - 2) / 41], (t - 2) % 41);
            chk($sformatf("ovf_tx_t%0d", t), {31'b0, uart_tx}, {31'b0, exp_tx});
            if (t == 6) chk("ovf_status_set", io_data_read, 32'h0000_0019);
            if (t == 8) chk("ovf_status_cleared", io_data_read, 32'h0000_0011);
            cyc();
        end
        $display("seq uart overflow burst done");

        // Reset during the DATA phase flushes the queued byte.
        for (int t = 0; t <= 12; t++) begin
            if (t == 0)      drive(1'b1, 1'b1, 8'h10, 32'h0000_00A5);
            else if (t == 1) drive(1'b1, 1'b1, 8'h10, 32'h0000_003C);
            else             drive(1'b0, 1'b0, 8'h00, 32'h0);
            if (t == 12) reset = 1'b1;
            #1;
            exp_tx = (t >= 2) ? frame_bit(8'hA5, t - 2) : 1'b1;
            chk($sformatf("rstmid_tx_t%0d", t), {31'b0, uart_tx}, {31'b0, exp_tx});
            cyc();
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'h14, 32'h0);
        #1;
        chk("rstmid_tx_after", {31'b0, uart_tx}, 32'h1);
        chk("rstmid_status", io_data_read, 32'h0000_0002);
        cyc();
        drive(1'b1, 1'b0, 8'h0C, 32'h0);
        #1;
        chk("rstmid_cmp", io_data_read, 32'hFFFF_FFFF);
        chk("rstmid_gpio", {24'b0, gpio_out}, 32'h0);
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 60; i++) begin
            cyc();
            chk($sformatf("rstmid_quiet_c%0d", i), {31'b0, uart_tx}, 32'h1);
        end
        $display("seq reset mid-frame done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bank.md
# io_bank

Responder for the MMU's I/O port window (0x80000000–0x800000FF). It decodes `io_addr`/`io_en`/`io_we`, returns `io_data_read` in the same cycle, and commits writes at the end of that cycle. It hosts the following peripherals:

- GPIO out and GPIO in.
- A 32-bit timer with compare and a pending flag.
- A UART transmitter fed by a 4-entry FIFO.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104, clock cycles per UART bit (≥2).
- `TX_FIFO_DEPTH`, 4, UART TX FIFO entries (power of two).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `io_addr`  in  8  byte offset into I/O window; `[1:0]` ignored.
- `io_en`  in  1  access valid this cycle.
- `io_we`  in  1  write when `io_en`.
- `io_data_write`  in  32  write data, full word.
- `io_data_read`  out  32  read data, combinational from current inputs/state.
- `gpio_out`  out  8  LED/GPIO output register.
- `gpio_in`  in  8  asynchronous external inputs.
- `uart_tx`  out  1  serial line, idle high.
- `timer_irq`  out  1  equals timer pending flag.

## Operation
- All registers are word-wide. Accesses are treated as full-word; writes use `io_data_write[31:0]`.
- Register map (offset):
  - 0x00 GPIO_OUT, RW, bits [7:0].
  - 0x04 GPIO_IN, RO, `{24'b0, gpio_in}` after a two-flop synchronizer.
  - 0x08 TIMER, RW. Free-running +1 per cycle; a write loads the value and wins over the increment.
  - 0x0C TIMER_CMP, RW, reset 0xFFFFFFFF.
  - 0x10 UART_TX, WO. A write pushes `[7:0]` into the FIFO. Reads return 0.
  - 0x14 STATUS:
    - bit0 tx_full.
    - bit1 tx_empty.
    - bit2 timer_pending (W1C).
    - bit3 tx_overflow (sticky, W1C).
    - bit4 tx_busy.
    - Other bits read 0.
- Unmapped offsets read 0; writes to them are ignored. When `io_en`=0, `io_data_read`=0 and there are no side effects.
- Timer compare: when TIMER==TIMER_CMP (pre-edge values), pending is set at that edge. Set wins over a simultaneous W1C.
- FIFO full/overflow:
  - Fullness is judged on the pre-edge count.
  - A push when full is dropped and sets tx_overflow, even if a pop occurs in the same cycle.
  - Push+pop when not full leaves the count unchanged.
  - Pointers wrap modulo `TX_FIFO_DEPTH`.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - In IDLE with the FIFO non-empty: pop the head into the shift register and go to START.
  - START drives 0.
  - DATA sends 8 bits LSB first.
  - STOP drives 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles, counted by a bit-cycle counter and a 3-bit bit index.
  - tx_busy = (state≠IDLE).
- Reset values:
  - `gpio_out`=0, TIMER=0, TIMER_CMP=0xFFFFFFFF.
  - Pending=0, overflow=0, FIFO empty.
  - FSM IDLE, `uart_tx`=1, `timer_irq`=0.
  - Synchronizer flops 0.

## Timing
- Read latency is 0: the MMU registers the access, and `io_data_read` must be valid in that same cycle.
- Write and pop side effects take effect at the rising edge that ends the `io_en` cycle.
- `gpio_in` reaches GPIO_IN 2 edges after a stable change.
- UART frame timing:
  - The first START cycle follows the edge after the push (1-cycle IDLE observation).
  - A frame lasts 10·`CLKS_PER_BIT` cycles.
  - Back-to-back frames have exactly 1 IDLE cycle between the STOP end and the next START.
- Reset mid-frame: `uart_tx` is 1 after the reset edge, the FIFO is flushed, and the in-flight byte is lost.
- `timer_irq` rises 1 cycle after TIMER equals TIMER_CMP.

## Structure
- Shared package `io_bank_pkg`:
  - Register offset constants (`IO_GPIO_OUT`…`IO_STATUS`).
  - STATUS bit indices.
  - TX FSM state encoding.
- Sub-module `io_uart_tx` holds the FIFO, FSM and counters. Its interface:
  - Inputs `push`, `push_data[7:0]`, `clr_overflow`.
  - Outputs `full`, `empty`, `overflow`, `busy`, `uart_tx`.
- The top level contains decode, GPIO, synchronizer and timer.

## Test plan
- Reset → reads:
  - 0x14 reads 0x00000002.
  - 0x0C reads 0xFFFFFFFF.
  - `uart_tx`=1 and `gpio_out`=0.
- Write 0x000000A5 to 0x00 → next cycle `gpio_out`=0xA5, and a read of 0x00 returns 0xA5. Read 0x40 returns 0.
- Timer:
  - Write TIMER=10 and TIMER_CMP=15; `timer_irq` rises exactly 6 cycles after the TIMER write edge.
  - Write 0x4 to 0x14 → `timer_irq` falls.
  - A W1C coinciding with a match leaves it at 1.
- UART, with `CLKS_PER_BIT`=4:
  - Write 0x55 to 0x10 → `uart_tx` shows 0,1,0,1,0,1,0,1,0,1, each 4 cycles, totalling 40 cycles.
  - tx_busy reads 1 during the frame.
- Overflow:
  - With `CLKS_PER_BIT`=4, push 6 bytes on consecutive cycles → 1 enters the shifter and 4 fill the FIFO (full=1), so the 6th is dropped and overflow=1.
  - 5 frames are emitted with 1-cycle gaps.
  - Writing 0x8 to 0x14 clears overflow.
- Reset asserted mid-DATA → next cycle `uart_tx`=1, STATUS=0x00000002, and no further frames are sent.
